// File: rtl/clock_text_gen_if.sv
// ============================================================================
// Module      : clock_text_gen_if
// Description : Pixel-stream, digit and font-ROM signals of clock_text_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clock_text_gen_if;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        sec_tick;
  logic [3:0]  hr_t;
  logic [3:0]  hr_o;
  logic [3:0]  min_t;
  logic [3:0]  min_o;
  logic [3:0]  sec_t;
  logic [3:0]  sec_o;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        text_on;
  logic [11:0] rgb;

  modport master (
    output video_on, x, y, sec_tick,
    output hr_t, hr_o, min_t, min_o, sec_t, sec_o,
    output rom_data,
    input  rom_addr, text_on, rgb
  );

  modport slave (
    input  video_on, x, y, sec_tick,
    input  hr_t, hr_o, min_t, min_o, sec_t, sec_o,
    input  rom_data,
    output rom_addr, text_on, rgb
  );
endinterface

`default_nettype wire

// File: rtl/clock_text_gen.sv
// ============================================================================
// Module      : clock_text_gen
// Description : "HH:MM:SS" pixel text generator between VGA timing and a
//               synchronous 8x16 font ROM. Optional macro: COLON_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_text_gen #(
  parameter int          X0         = 192,
  parameter int          Y0         = 208,
  parameter int          SCALE_LOG2 = 2,
  parameter logic [11:0] FG_COLOR   = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  clock_text_gen_if.slave bus
);

  localparam int          c_FIELD_W    = 64 << SCALE_LOG2;
  localparam int          c_FIELD_H    = 16 << SCALE_LOG2;
  localparam logic [10:0] c_X_LO       = 11'(X0);
  localparam logic [10:0] c_X_HI       = 11'(X0 + c_FIELD_W);
  localparam logic [10:0] c_Y_LO       = 11'(Y0);
  localparam logic [10:0] c_Y_HI       = 11'(Y0 + c_FIELD_H);
  localparam logic [6:0]  c_CODE_ZERO  = 7'h30;
  localparam logic [6:0]  c_CODE_COLON = 7'h3A;
  localparam logic [10:0] c_ADDR_IDLE  = 11'h300;

  // Frame-held digit snapshot: {hr_t, hr_o, min_t, min_o, sec_t, sec_o}
  logic [23:0] snap_q, snap_d;
  logic        frame_start;

  assign frame_start = (bus.x == 10'd0) && (bus.y == 10'd0);
  assign snap_d      = frame_start ? {bus.hr_t, bus.hr_o, bus.min_t,
                                      bus.min_o, bus.sec_t, bus.sec_o}
                                   : snap_q;

  always_ff @(posedge clk) begin
    if (!reset_n) snap_q <= 24'd0;
    else          snap_q <= snap_d;
  end

  logic blink_on;
`ifdef COLON_BLINK_EN
  logic blink_q, blink_d;

  assign blink_d  = bus.sec_tick ? ~blink_q : blink_q;
  assign blink_on = blink_q;

  always_ff @(posedge clk) begin
    if (!reset_n) blink_q <= 1'b1;
    else          blink_q <= blink_d;
  end
`else
  assign blink_on = 1'b1;
`endif

  // dx/dy may wrap below the field origin; in_field alone rejects those.
  logic [9:0] dx, dy;
  logic       in_field;
  logic [2:0] char_idx;
  logic [2:0] col;
  logic [3:0] row;

  assign dx       = bus.x - 10'(X0);
  assign dy       = bus.y - 10'(Y0);
  assign in_field = ({1'b0, bus.x} >= c_X_LO) && ({1'b0, bus.x} < c_X_HI) &&
                    ({1'b0, bus.y} >= c_Y_LO) && ({1'b0, bus.y} < c_Y_HI);
  assign char_idx = 3'(dx >> (3 + SCALE_LOG2));
  assign col      = 3'(dx >> SCALE_LOG2);
  assign row      = 4'(dy >> SCALE_LOG2);

  logic [3:0] digit;
  logic       colon_cell;
  logic       blank;
  logic [6:0] code;

  always_comb begin
    digit      = 4'd0;
    colon_cell = 1'b0;
    case (char_idx)
      3'd0:    digit      = snap_q[23:20];
      3'd1:    digit      = snap_q[19:16];
      3'd3:    digit      = snap_q[15:12];
      3'd4:    digit      = snap_q[11:8];
      3'd6:    digit      = snap_q[7:4];
      3'd7:    digit      = snap_q[3:0];
      default: colon_cell = 1'b1;
    endcase
  end

  assign blank        = ~colon_cell && (digit > 4'd9);
  assign code         = colon_cell ? c_CODE_COLON :
                        blank      ? c_CODE_ZERO  :
                                     c_CODE_ZERO + {3'b000, digit};
  assign bus.rom_addr = in_field ? {code, row} : c_ADDR_IDLE;

  // Stage 1: attributes that must line up with the ROM's registered read
  logic [2:0] col_q;
  logic       in_field_q;
  logic       blank_q;
  logic       colon_q;
  logic       video_on_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_q      <= 3'd0;
      in_field_q <= 1'b0;
      blank_q    <= 1'b0;
      colon_q    <= 1'b0;
      video_on_q <= 1'b0;
    end else begin
      col_q      <= col;
      in_field_q <= in_field;
      blank_q    <= blank;
      colon_q    <= colon_cell;
      video_on_q <= bus.video_on;
    end
  end

  // Stage 2: pick the glyph bit and colour the pixel
  logic        pix;
  logic        text_on_q, text_on_d;
  logic [11:0] rgb_q, rgb_d;

  assign pix       = bus.rom_data[3'd7 - col_q] & in_field_q & ~blank_q &
                     ~(colon_q & ~blink_on);
  assign text_on_d = pix & video_on_q;
  assign rgb_d     = !video_on_q ? 12'h000 : (pix ? FG_COLOR : BG_COLOR);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      text_on_q <= 1'b0;
      rgb_q     <= 12'h000;
    end else begin
      text_on_q <= text_on_d;
      rgb_q     <= rgb_d;
    end
  end

  assign bus.text_on = text_on_q;
  assign bus.rgb     = rgb_q;

endmodule

`default_nettype wire

// File: doc/clock_text_gen.md
Name: clock_text_gen

Overview:
- Pixel-level text generator for the "HH:MM:SS" clock display.
- Sits between the VGA sync/pixel counter and the 8x16 digit font ROM:
  - upstream of the ROM, it forms the ROM address;
  - downstream of the ROM, it consumes the row bitmap and produces the per-pixel RGB.
- Snapshots the time digits once per frame, aligns to the ROM's one-cycle read latency, and blinks the colons from a seconds tick.

Parameters:
- X0, 192: left pixel column of the text field.
- Y0, 208: top pixel row of the text field.
- SCALE_LOG2, 2: glyph magnification is 2^SCALE_LOG2 in both axes. The default gives 32x64 cells, so the field is 256x64.
- FG_COLOR, 12'hFFF: RGB444 value for lit glyph pixels.
- BG_COLOR, 12'h000: RGB444 value for unlit pixels inside video_on.

Ports:
- clk  in  1  system/pixel clock
- reset_n  in  1  synchronous, active-low reset
- video_on  in  1  high in the visible area
- x  in  10  current pixel column
- y  in  10  current pixel row
- sec_tick  in  1  one-cycle pulse once per second
- hr_t, hr_o, min_t, min_o, sec_t, sec_o  in  4 each  BCD digits
- rom_addr  out  11  font ROM address {char_code[6:0], row[3:0]}
- rom_data  in  8  font ROM row bitmap; bit 7 is the leftmost pixel; valid one clk after rom_addr
- text_on  out  1  registered; lit glyph pixel
- rgb  out  12  registered pixel colour

Behaviour:
- Reset (reset_n low at a clk edge):
  - rgb=0, text_on=0.
  - All pipeline registers = 0.
  - Digit snapshot = 0.
  - blink_on = 1.
  - Reset has priority over every other event in the same cycle.
- Digit snapshot:
  - All six BCD inputs are captured together on a cycle with x==0 && y==0.
  - They are held for the rest of the frame, so a mid-frame digit change must not tear the display.
- Field geometry:
  - dx=x-X0, dy=y-Y0, both 10-bit.
  - in_field = (x>=X0) && (x<X0+(64<<SCALE_LOG2)) && (y>=Y0) && (y<Y0+(16<<SCALE_LOG2)).
  - char_idx = dx>>(3+SCALE_LOG2), range 0..7.
  - row = (dy>>SCALE_LOG2)[3:0].
  - col = (dx>>SCALE_LOG2)[2:0].
- Character map by char_idx:
  - 0: hr_t, 1: hr_o, 2: colon, 3: min_t, 4: min_o, 5: colon, 6: sec_t, 7: sec_o.
  - Digit code = 7'h30+digit. Colon code = 7'h3A.
- Blank handling:
  - A digit value >9 marks the cell blank.
  - A blank cell drives code 7'h30 and forces its pixel off.
- rom_addr:
  - Combinational: {code, row} when in_field.
  - 11'h300 otherwise.
- Pipeline:
  - Stage 1 (edge after x/y are presented) registers col, in_field, blank, colon_cell and video_on. The ROM registers rom_addr on the same edge.
  - Stage 2 computes pix = rom_data[7-col_d1] & in_field_d1 & ~blank_d1 & ~(colon_d1 & ~blink_on), then registers:
    - text_on = pix & video_on_d1;
    - rgb = ~video_on_d1 ? 0 : (pix ? FG_COLOR : BG_COLOR).
  - Total latency from x/y to rgb/text_on is 2 clks. Throughput is one pixel per clk.
- Blink:
  - blink_on toggles on each sec_tick.
  - A sec_tick in the same cycle as a frame-start snapshot takes effect independently.
- Boundaries:
  - x or y below X0/Y0 wraps dx/dy and must be excluded by the in_field compare, not by the shift result.
  - Last field column X0+255 maps to char 7, col 7.

Optional Feature:
- Macro: COLON_BLINK_EN.
- Defined: colons are lit only while blink_on=1, and blink_on toggles per sec_tick.
- Undefined:
  - blink_on logic is not built and sec_tick is ignored.
  - Colons are always lit.
  - All other timing is identical.

Test Plan:
- Reset: hold reset_n=0 for 3 clks with video_on=1, x=200, y=216 -> rgb=12'h000 and text_on=0 throughout; after release the first valid rgb appears at the 2nd edge.
- Glyph lookup: snapshot digits 1,2,3,4,5,6 at x=0,y=0; present x=204, y=216 -> rom_addr=11'h312; 2 clks later text_on=1, rgb=12'hFFF. Present x=192 -> rgb=12'h000.
- Colon blink (COLON_BLINK_EN): x=268, y=224 -> rom_addr=11'h3A4, text_on=1. Pulse sec_tick -> text_on=0 at the same x/y; pulse again -> text_on=1.
- Tear-free: change min_o from 4 to 7 mid-frame -> rom_addr for x=192+4*32 still uses 7'h34 until the next x=0,y=0, then 7'h37.
- Invalid/outside: set sec_o=4'hC -> char 7 pixels all BG. At x=191 or y=272 -> rom_addr=11'h300, rgb=BG_COLOR. With video_on=0 -> rgb=12'h000.
